// File: rtl/dsi_ppi_pkg.sv
// rtl/dsi_ppi_pkg.sv - shared constants and types for the DSI PPI lane distributor
package dsi_ppi_pkg;

  localparam int MAX_LANES = 4;
  localparam int BUF_BYTES = 8;

  typedef logic [1:0] lane_cnt_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    GAP    = 2'd2
  } dist_state_t;

  // Byte 0 occupies bits [7:0] and is always the oldest / first-transmitted byte.
  typedef logic [MAX_LANES-1:0][7:0] lane_bytes_t;

  // A beat never carries more than four bytes; larger counts are treated as four.
  function automatic logic [2:0] clamp_bytes(input logic [2:0] b);
    return (b > 3'd4) ? 3'd4 : b;
  endfunction

endpackage

// File: rtl/dsi_byte_ring8.sv
// rtl/dsi_byte_ring8.sv - 8-byte ring buffer with 0-4 byte push and pop per cycle
module dsi_byte_ring8
  import dsi_ppi_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [2:0]  push_cnt_i,
  input  lane_bytes_t push_data_i,
  input  logic [2:0]  pop_cnt_i,
  output logic [3:0]  occ_o,
  output lane_bytes_t peek_o
);

  logic [7:0] mem_q [BUF_BYTES];
  logic [2:0] rd_ptr_q, rd_ptr_d;
  logic [3:0] occ_q, occ_d;
  logic [2:0] wr_ptr;

  // Writes land just past the live bytes; the pop of the same cycle only frees older slots.
  assign wr_ptr = rd_ptr_q + occ_q[2:0];
  assign occ_o  = occ_q;

  // Next read pointer and occupancy; the caller guarantees no overflow or over-pop.
  always_comb begin
    rd_ptr_d = rd_ptr_q + pop_cnt_i;
    occ_d    = occ_q + {1'b0, push_cnt_i} - {1'b0, pop_cnt_i};
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_ptr_q <= 3'd0;
      occ_q    <= 4'd0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Byte storage needs no reset: occupancy alone marks which slots are live.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < MAX_LANES; i++) begin
      if (3'(i) < push_cnt_i) begin
        mem_q[wr_ptr + 3'(i)] <= push_data_i[i];
      end
    end
  end

  // Oldest-first view of the next four bytes.
  always_comb begin
    for (int j = 0; j < MAX_LANES; j++) begin
      peek_o[j] = mem_q[rd_ptr_q + 3'(j)];
    end
  end

endmodule

// File: rtl/dsi_ppi_lane_distributor.sv
// rtl/dsi_ppi_lane_distributor.sv - stripes a packet byte stream round-robin over 1-4 PPI HS lanes
module dsi_ppi_lane_distributor
  import dsi_ppi_pkg::*;
#(
  parameter int GAP_CYCLES = 4,
  parameter int BUF_BYTES  = 8
) (
  input  logic        ppi_clk,
  input  logic        ppi_rst_n,
  input  lane_cnt_t   cfg_lane_cnt,
  input  logic [31:0] s_data,
  input  logic [2:0]  s_bytes,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [7:0]  PPI_DATA_LANE0,
  output logic [7:0]  PPI_DATA_LANE1,
  output logic [7:0]  PPI_DATA_LANE2,
  output logic [7:0]  PPI_DATA_LANE3,
  output logic        PPI_LANE0_EN,
  output logic        PPI_LANE1_EN,
  output logic        PPI_LANE2_EN,
  output logic        PPI_LANE3_EN,
  output logic        busy,
  output logic        err_underflow,
  input  logic        err_clr
);

  // A full 4-byte beat must always fit, so accept only while at most half full.
  localparam logic [3:0] READY_MAX = 4'(BUF_BYTES - MAX_LANES);
  localparam logic [7:0] GAP_LAST  = 8'(GAP_CYCLES - 1);

  dist_state_t state_q, state_d;
  logic [2:0]  lanes_q, lanes_d;
  logic        last_pend_q, last_pend_d;
  logic [7:0]  gap_cnt_q, gap_cnt_d;
  logic        err_q, err_d;
  logic [3:0]  emit_en_q, emit_en_d, out_en_q;
  lane_bytes_t emit_data_q, emit_data_d, out_data_q;

  logic [3:0]  occ;
  lane_bytes_t peek;
  logic [2:0]  push_cnt, pop_cnt;
  logic        accept;
  logic [2:0]  cfg_lanes, eff_lanes;
  logic        do_emit;

  assign s_ready   = ppi_rst_n && (occ <= READY_MAX) && !last_pend_q;
  assign accept    = s_valid && s_ready;
  assign push_cnt  = accept ? clamp_bytes(s_bytes) : 3'd0;
  assign cfg_lanes = {1'b0, cfg_lane_cnt} + 3'd1;
  // The first emission of a burst already uses the newly sampled lane count.
  assign eff_lanes = (state_q == IDLE) ? cfg_lanes : lanes_q;

  dsi_byte_ring8 u_ring (
    .clk_i       (ppi_clk),
    .rst_ni      (ppi_rst_n),
    .push_cnt_i  (push_cnt),
    .push_data_i (s_data),
    .pop_cnt_i   (pop_cnt),
    .occ_o       (occ),
    .peek_o      (peek)
  );

  // Burst sequencing: start, per-cycle pop size, end of packet, underflow and gap timing.
  always_comb begin
    state_d     = state_q;
    lanes_d     = lanes_q;
    last_pend_d = last_pend_q;
    gap_cnt_d   = gap_cnt_q;
    err_d       = err_q && !err_clr;
    pop_cnt     = 3'd0;
    do_emit     = 1'b0;

    case (state_q)
      IDLE: begin
        if ((occ >= {1'b0, cfg_lanes}) || (last_pend_q && (occ != 4'd0))) begin
          lanes_d = cfg_lanes;
          do_emit = 1'b1;
        end else if (last_pend_q) begin
          // Empty packet: nothing to send, just retire its end marker.
          last_pend_d = 1'b0;
        end
      end
      ACTIVE: begin
        do_emit = 1'b1;
      end
      GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (do_emit) begin
      state_d = ACTIVE;
      if (occ > {1'b0, eff_lanes}) begin
        pop_cnt = eff_lanes;
      end else if (last_pend_q) begin
        pop_cnt     = occ[2:0];
        last_pend_d = 1'b0;
        state_d     = GAP;
        gap_cnt_d   = 8'd0;
      end else if (occ == {1'b0, eff_lanes}) begin
        pop_cnt = eff_lanes;
      end else begin
        // Starved mid-packet: close this burst; leftovers open a new one after the gap.
        err_d     = 1'b1;
        state_d   = GAP;
        gap_cnt_d = 8'd0;
      end
    end

    if (accept && s_last) begin
      last_pend_d = 1'b1;
    end
  end

  // Lane byte/enable decode for the bytes popped this cycle; idle lanes drive zero.
  always_comb begin
    emit_en_d   = 4'd0;
    emit_data_d = '0;
    for (int j = 0; j < MAX_LANES; j++) begin
      emit_en_d[j]   = (3'(j) < pop_cnt);
      emit_data_d[j] = emit_en_d[j] ? peek[j] : 8'h00;
    end
  end

  // Control state and the two-stage registered lane outputs.
  always_ff @(posedge ppi_clk) begin
    if (!ppi_rst_n) begin
      state_q     <= IDLE;
      lanes_q     <= 3'd1;
      last_pend_q <= 1'b0;
      gap_cnt_q   <= 8'd0;
      err_q       <= 1'b0;
      emit_en_q   <= 4'd0;
      emit_data_q <= '0;
      out_en_q    <= 4'd0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      lanes_q     <= lanes_d;
      last_pend_q <= last_pend_d;
      gap_cnt_q   <= gap_cnt_d;
      err_q       <= err_d;
      emit_en_q   <= emit_en_d;
      emit_data_q <= emit_data_d;
      out_en_q    <= emit_en_q;
      out_data_q  <= emit_data_q;
    end
  end

  assign PPI_DATA_LANE0 = out_data_q[0];
  assign PPI_DATA_LANE1 = out_data_q[1];
  assign PPI_DATA_LANE2 = out_data_q[2];
  assign PPI_DATA_LANE3 = out_data_q[3];
  assign PPI_LANE0_EN   = out_en_q[0];
  assign PPI_LANE1_EN   = out_en_q[1];
  assign PPI_LANE2_EN   = out_en_q[2];
  assign PPI_LANE3_EN   = out_en_q[3];
  assign busy           = (state_q != IDLE) || (occ != 4'd0);
  assign err_underflow  = err_q;

endmodule
